sram_arb_ctrl: RTL and testbench

//  Two-requester round-robin arbiter and access sequencer for the asynchronous 8-bit SRAM.

---
 rtl/sram_arb_ctrl.sv | 129 ++++++++++++
 tb/tb_sram_arb_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arb_ctrl.sv
// sram_arb_ctrl: round-robin arbiter for two req/ack ports sharing one
// asynchronous 8-bit SRAM. It turns each granted transaction into a fixed
// read (RD1, RD2) or write (WR1..WR3) strobe sequence, then a one-cycle ack.
module sram_arb_ctrl #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic          busy,
    output logic          sram_read,
    output logic          sram_write,
    output logic [AW-1:0] sram_addr,
    inout  wire  [DW-1:0] sram_data
);

    typedef enum logic [2:0] {IDLE, RD1, RD2, WR1, WR2, WR3, ACK} state_t;

    state_t        state;
    state_t        state_n;
    logic          accept;
    logic          grant_b;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          gnt_b;
    logic          last_b;
    logic          drive_en;
    logic [DW-1:0] wdata_q;

    assign sram_data = drive_en ? wdata_q : {DW{1'bz}};

    // State register; reset aborts any access in flight and returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Arbitration, next-state and ack/busy decode; a tie goes to the port that was not served last.
    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        grant_b   = 1'b0;
        sel_we    = a_we;
        sel_addr  = a_addr;
        sel_wdata = a_wdata;
        busy      = (state != IDLE);
        a_ack     = (state == ACK) && !gnt_b;
        b_ack     = (state == ACK) && gnt_b;
        case (state)
            IDLE: begin
                if (a_req || b_req) begin
                    accept  = 1'b1;
                    grant_b = b_req && (!a_req || !last_b);
                    if (grant_b) begin
                        sel_we    = b_we;
                        sel_addr  = b_addr;
                        sel_wdata = b_wdata;
                    end
                    state_n = sel_we ? WR1 : RD1;
                end
            end
            RD1:     state_n = RD2;
            RD2:     state_n = ACK;
            WR1:     state_n = WR2;
            WR2:     state_n = WR3;
            WR3:     state_n = ACK;
            ACK:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Registered SRAM strobes, address, bus drive and per-port read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_b      <= 1'b0;
            last_b     <= 1'b1;
            drive_en   <= 1'b0;
            wdata_q    <= '0;
            sram_read  <= 1'b0;
            sram_write <= 1'b0;
            sram_addr  <= '0;
            a_rdata    <= '0;
            b_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        gnt_b      <= grant_b;
                        last_b     <= grant_b;
                        sram_addr  <= sel_addr;
                        wdata_q    <= sel_wdata;
                        sram_read  <= !sel_we;
                        drive_en   <= sel_we;
                        sram_write <= 1'b0;
                    end
                end
                RD2: begin
                    if (gnt_b) begin
                        b_rdata <= sram_data;
                    end else begin
                        a_rdata <= sram_data;
                    end
                    sram_read <= 1'b0;
                end
                WR1: sram_write <= 1'b1;
                WR2: sram_write <= 1'b0;
                WR3: drive_en   <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// tb_sram_arb_ctrl: scoreboard bench for sram_arb_ctrl with a behavioural SRAM.
// The stimulus side predicts grant order and memory contents and queues the
// expected responses; the monitor pops and compares whenever an ack appears.
module tb_sram_arb_ctrl;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_req, a_we, a_ack;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_req, b_we, b_ack;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          busy, sram_read, sram_write;
    logic [AW-1:0] sram_addr;
    wire  [DW-1:0] sram_data;

    logic [DW-1:0] sram_mem [32];

    typedef struct {
        bit            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    txn_t          scoreQ[$];
    logic [DW-1:0] refMem [32];
    bit            lastB;
    bit            expectIdle = 1'b0;
    bit            done = 1'b0;
    int            timeouts = 0;

    int            checks = 0;
    int            failures = 0;
    int            busyCnt = 0;
    logic [DW-1:0] expARd = '0;
    logic [DW-1:0] expBRd = '0;

    sram_arb_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .busy(busy), .sram_read(sram_read), .sram_write(sram_write),
        .sram_addr(sram_addr), .sram_data(sram_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] memInit(input int i);
        return DW'((i * 37 + 11) & 255);
    endfunction

    // Asynchronous SRAM: drives the bus while read is enabled, stores on the rising write strobe.
    assign sram_data = sram_read ? sram_mem[sram_addr] : {DW{1'bz}};

    initial begin
        for (int i = 0; i < 32; i++) sram_mem[i] = memInit(i);
        forever begin
            @(posedge sram_write);
            sram_mem[sram_addr] = sram_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the served port becomes last grant, writes update memory, reads take its value.
    task automatic modelPush(input bit pb, input bit we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data);
        txn_t t;
        t.port = pb;
        t.we   = we;
        t.addr = addr;
        if (we) begin
            refMem[addr] = data;
            t.data = data;
        end else begin
            t.data = refMem[addr];
        end
        scoreQ.push_back(t);
        lastB = pb;
    endtask

    task automatic drivePort(input bit pb, input bit we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data);
        bit got;
        @(negedge clk);
        if (!pb) begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = data;
        end else begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = data;
        end
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            got = pb ? b_ack : a_ack;
        end
        if (!got) begin
            $display("[TB] FAIL ack_timeout port=%0d got=0 want=1", pb);
            timeouts++;
        end
        if (!pb) a_req = 1'b0;
        else     b_req = 1'b0;
    endtask

    task automatic applyStimulus(input bit pb, input bit we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data);
        modelPush(pb, we, addr, data);
        drivePort(pb, we, addr, data);
    endtask

    task automatic applyDual(input bit aWe, input logic [AW-1:0] aAddr, input logic [DW-1:0] aData,
                             input bit bWe, input logic [AW-1:0] bAddr, input logic [DW-1:0] bData);
        if (lastB) begin
            modelPush(1'b0, aWe, aAddr, aData);
            modelPush(1'b1, bWe, bAddr, bData);
        end else begin
            modelPush(1'b1, bWe, bAddr, bData);
            modelPush(1'b0, aWe, aAddr, aData);
        end
        fork
            drivePort(1'b0, aWe, aAddr, aData);
            drivePort(1'b1, bWe, bAddr, bData);
        join
    endtask

    task automatic resetDut();
        @(negedge clk);
        #2 rst_n = 1'b0;
        lastB = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Stimulus: directed scenarios, then random single and contending transactions, then a reset abort.
    initial begin
        bit abortSeen;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        rst_n = 1'b0;
        lastB = 1'b1;
        for (int i = 0; i < 32; i++) refMem[i] = memInit(i);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        expectIdle = 1'b1;
        repeat (10) @(negedge clk);
        expectIdle = 1'b0;

        applyStimulus(1'b0, 1'b1, 5'd5, 8'hA5);
        applyStimulus(1'b0, 1'b0, 5'd5, 8'h00);

        resetDut();
        applyDual(1'b1, 5'd4, 8'hC3, 1'b1, 5'd3, 8'h3C);
        applyStimulus(1'b0, 1'b0, 5'd4, 8'h00);
        applyStimulus(1'b1, 1'b0, 5'd3, 8'h00);

        applyDual(1'b0, 5'd4, 8'h00, 1'b0, 5'd3, 8'h00);
        applyDual(1'b0, 5'd5, 8'h00, 1'b0, 5'd4, 8'h00);

        applyStimulus(1'b0, 1'b1, 5'd31, 8'h01);
        applyStimulus(1'b1, 1'b1, 5'd0, 8'h80);
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        applyStimulus(1'b1, 1'b0, 5'd31, 8'h00);

        for (int r = 0; r < 40; r++) begin
            int kind;
            kind = $urandom_range(0, 2);
            if (kind == 2)
                applyDual(1'($urandom), 5'($urandom), 8'($urandom),
                          1'($urandom), 5'($urandom), 8'($urandom));
            else
                applyStimulus(1'(kind), 1'($urandom), 5'($urandom), 8'($urandom));
        end

        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = 5'd7; a_wdata = 8'hFF;
        abortSeen = 1'b0;
        for (int c = 0; c < 10 && !abortSeen; c++) begin
            @(negedge clk);
            abortSeen = busy;
        end
        if (!abortSeen) begin
            $display("[TB] FAIL abort_busy got=0 want=1");
            timeouts++;
        end
        #2 rst_n = 1'b0;
        lastB = 1'b1;
        a_req = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        expectIdle = 1'b1;
        repeat (4) @(negedge clk);
        expectIdle = 1'b0;
        applyStimulus(1'b0, 1'b0, 5'd7, 8'h00);

        repeat (3) @(negedge clk);
        done = 1'b1;
    end

    // Monitor: reset values, strobe rules, and scoreboard comparison on every ack.
    always @(negedge clk) begin
        txn_t t;
        if (!rst_n) begin
            check("reset_outputs",
                  32'({a_ack, b_ack, busy, sram_read, sram_write, sram_addr, a_rdata, b_rdata}), 32'd0);
            busyCnt = 0;
            expARd  = '0;
            expBRd  = '0;
        end else begin
            if (busy) busyCnt++;
            else      busyCnt = 0;
            if (expectIdle) check("idle_busy", 32'(busy), 32'd0);
            if (sram_read || sram_write) begin
                check("strobe_overlap", 32'(sram_read & sram_write), 32'd0);
                check("pending_txn", 32'(scoreQ.size() > 0), 32'd1);
                if (scoreQ.size() > 0) begin
                    t = scoreQ[0];
                    check("sram_addr", 32'(sram_addr), 32'(t.addr));
                    check("strobe_kind", 32'(sram_read), 32'(!t.we));
                    if (sram_write) check("sram_wdata", 32'(sram_data), 32'(t.data));
                end
            end
            if (a_ack || b_ack) begin
                check("dual_ack", 32'(a_ack & b_ack), 32'd0);
                check("ack_expected", 32'(scoreQ.size() > 0), 32'd1);
                if (scoreQ.size() > 0) begin
                    t = scoreQ.pop_front();
                    check("ack_port", 32'(b_ack), 32'(t.port));
                    check("latency", 32'(busyCnt), t.we ? 32'd4 : 32'd3);
                    if (!t.we) begin
                        if (t.port) expBRd = t.data;
                        else        expARd = t.data;
                    end
                    check("a_rdata", 32'(a_rdata), 32'(expARd));
                    check("b_rdata", 32'(b_rdata), 32'(expBRd));
                end
            end
        end
        if (done) begin
            check("queue_drained", 32'(scoreQ.size()), 32'd0);
            check("timeouts", 32'(timeouts), 32'd0);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired got=running want=finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
